// File: rtl/edf_pkg.sv
// -----------------------------------------------------------------------------
// edf_pkg
//   Shared constants and types for the EDF release controller and the scheduler
//   skeleton, so that task ids and time widths agree on both sides.
//   Contents:
//     MAX_TASKS, MAX_TASK_BITS  task slot count and id width
//     TIME_W                    width of period/phase/counter values, in ticks
//     TICK_DIV_DEF              default clk cycles per scheduler tick
//     release_slot_t            per-slot state {en, per, cnt}
//     id_onehot()               task id -> one-hot slot mask
// -----------------------------------------------------------------------------
package edf_pkg;

   localparam int MAX_TASKS     = 16;
   localparam int MAX_TASK_BITS = $clog2(MAX_TASKS);
   localparam int TIME_W        = 16;
   localparam int TICK_DIV_DEF  = 4;

   typedef logic [MAX_TASK_BITS-1:0] task_id_t;
   typedef logic [TIME_W-1:0]        time_t;

   // en  : slot armed
   // per : release period in ticks (never 0 while armed)
   // cnt : ticks remaining until the next release
   typedef struct packed {
      logic  en;
      time_t per;
      time_t cnt;
   } release_slot_t;

   function automatic logic [MAX_TASKS-1:0] id_onehot(input task_id_t id);
      return MAX_TASKS'(1) << id;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Searches req starting at ptr+1 and wraps
//   around, so the slot named by ptr (the previous winner) has lowest priority.
//   Ports:
//     req       in  N   request bitmap
//     ptr       in  IW  index of the last granted slot
//     gnt_valid out 1   some request is set
//     gnt_id    out IW  winning slot index (0 when gnt_valid=0)
// -----------------------------------------------------------------------------
module rr_arbiter
   import edf_pkg::*;
#(
   parameter int N  = MAX_TASKS,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_id
);

   logic [IW-1:0] idx;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      // k runs 1..N so that ptr itself is visited last.
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx;
         end
      end
   end

endmodule

// File: rtl/edf_release_ctrl.sv
// -----------------------------------------------------------------------------
// edf_release_ctrl
//   Periodic job-release controller in front of the EDF scheduler core. Each
//   armed slot counts scheduler ticks; on expiry it releases a job, which is
//   queued as pending and issued as one wakeup beat. Issued jobs stay active
//   until the scheduler reports completion. A release that finds the previous
//   job of the same task still pending or active is a deadline overrun
//   (implicit deadline = period).
//
//   Handshake: every *_valid here is a plain one-cycle strobe with no ready.
//   cfg_valid and completion_valid are sampled on the rising edge they are
//   high; wakeup_valid is a registered beat the scheduler always consumes.
//
//   Ports:
//     clk, rst                      clock; asynchronous active-low reset
//     cfg_valid/id/enable/period/phase  slot configuration write
//     cfg_err                       pulse: arm request with period 0 rejected
//     completion_valid/id           running job finished
//     wakeup_valid/id               release beat to scheduler
//     overrun_valid/id              pulse: lowest-index task that overran
//     overrun_mask                  sticky per-task overrun flags
//     tick                          one-cycle pulse every TICK_DIV clk cycles
// -----------------------------------------------------------------------------
module edf_release_ctrl
   import edf_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid,
   input  logic [MAX_TASK_BITS-1:0] cfg_id,
   input  logic                     cfg_enable,
   input  logic [TIME_W-1:0]        cfg_period,
   input  logic [TIME_W-1:0]        cfg_phase,
   output logic                     cfg_err,
   input  logic                     completion_valid,
   input  logic [MAX_TASK_BITS-1:0] completion_id,
   output logic                     wakeup_valid,
   output logic [MAX_TASK_BITS-1:0] wakeup_id,
   output logic                     overrun_valid,
   output logic [MAX_TASK_BITS-1:0] overrun_id,
   output logic [MAX_TASKS-1:0]     overrun_mask,
   output logic                     tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // ---------------------------------------------------------------- state
   logic [PW-1:0]            presc_q, presc_d;
   release_slot_t            slots_q [MAX_TASKS];
   release_slot_t            slots_d [MAX_TASKS];
   logic [MAX_TASKS-1:0]     pending_q, pending_d;
   logic [MAX_TASKS-1:0]     active_q, active_d;
   logic [MAX_TASKS-1:0]     mask_q, mask_d;
   logic [MAX_TASK_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic                     wakeup_valid_q;
   logic [MAX_TASK_BITS-1:0] wakeup_id_q;
   logic                     overrun_valid_q;
   logic [MAX_TASK_BITS-1:0] overrun_id_q;
   logic                     cfg_err_q;

   // ---------------------------------------------------------- combinational
   logic                     cfg_accept;
   logic [MAX_TASKS-1:0]     wr_mask;
   logic [MAX_TASKS-1:0]     comp_mask;
   logic [MAX_TASKS-1:0]     rel;
   logic [MAX_TASKS-1:0]     ovr;
   logic [MAX_TASKS-1:0]     req;
   logic [MAX_TASKS-1:0]     gnt_oh;
   logic                     gnt_valid;
   logic [MAX_TASK_BITS-1:0] gnt_id;
   logic [MAX_TASK_BITS-1:0] ovr_id;

   // Prescaler: tick is decoded directly from the counter value.
   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   always_comb begin
      // Arm with period 0 is rejected and leaves the slot untouched; disarm
      // and legal arm both take ownership of the slot for this cycle.
      cfg_accept = cfg_valid & (~cfg_enable | (cfg_period != '0));
      wr_mask    = '0;
      if (cfg_accept) begin
         wr_mask[cfg_id] = 1'b1;
      end
      comp_mask = '0;
      if (completion_valid) begin
         comp_mask[completion_id] = 1'b1;
      end
      rel = '0;
      for (int i = 0; i < MAX_TASKS; i++) begin
         // A slot written this cycle skips the tick: config wins.
         rel[i] = tick & slots_q[i].en & ~wr_mask[i] & (slots_q[i].cnt == '0);
      end
      ovr = rel & (pending_q | active_q);
      // Fresh releases join the request set in the same cycle, giving one
      // cycle from tick to wakeup beat when uncontended. A slot being written
      // is masked so a disarmed job is never issued.
      req = (pending_q | rel) & ~wr_mask;
   end

   rr_arbiter #(
      .N  (MAX_TASKS),
      .IW (MAX_TASK_BITS)
   ) u_rr_arbiter (
      .req       (req),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      gnt_oh = gnt_valid ? id_onehot(gnt_id) : '0;
      // A release that finds pending already set is simply absorbed.
      pending_d = (pending_q | rel) & ~gnt_oh & ~wr_mask;
      // Grant is applied after completion so a same-cycle grant keeps the
      // new job active.
      active_d  = ((active_q & ~comp_mask) | gnt_oh) & ~wr_mask;
      mask_d    = (mask_q | ovr) & ~((cfg_accept & cfg_enable) ? wr_mask : '0);
      rr_ptr_d  = gnt_valid ? gnt_id : rr_ptr_q;
   end

   // Lowest-index overrunning task: scan downward so the last hit wins.
   always_comb begin
      ovr_id = '0;
      for (int i = MAX_TASKS - 1; i >= 0; i--) begin
         if (ovr[i]) begin
            ovr_id = MAX_TASK_BITS'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < MAX_TASKS; i++) begin
         slots_d[i] = slots_q[i];
         if (wr_mask[i]) begin
            if (cfg_enable) begin
               slots_d[i].en  = 1'b1;
               slots_d[i].per = cfg_period;
               slots_d[i].cnt = cfg_phase;
            end else begin
               slots_d[i].en = 1'b0;
            end
         end else if (rel[i]) begin
            slots_d[i].cnt = slots_q[i].per - TIME_W'(1);
         end else if (tick && slots_q[i].en) begin
            // Here cnt is known to be non-zero, so no underflow.
            slots_d[i].cnt = slots_q[i].cnt - TIME_W'(1);
         end
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q         <= '0;
         pending_q       <= '0;
         active_q        <= '0;
         mask_q          <= '0;
         rr_ptr_q        <= '0;
         wakeup_valid_q  <= 1'b0;
         wakeup_id_q     <= '0;
         overrun_valid_q <= 1'b0;
         overrun_id_q    <= '0;
         cfg_err_q       <= 1'b0;
         for (int i = 0; i < MAX_TASKS; i++) begin
            slots_q[i] <= '0;
         end
      end else begin
         presc_q         <= presc_d;
         pending_q       <= pending_d;
         active_q        <= active_d;
         mask_q          <= mask_d;
         rr_ptr_q        <= rr_ptr_d;
         wakeup_valid_q  <= gnt_valid;
         wakeup_id_q     <= gnt_valid ? gnt_id : '0;
         overrun_valid_q <= |ovr;
         overrun_id_q    <= ovr_id;
         cfg_err_q       <= cfg_valid & cfg_enable & (cfg_period == '0);
         for (int i = 0; i < MAX_TASKS; i++) begin
            slots_q[i] <= slots_d[i];
         end
      end
   end

   assign wakeup_valid  = wakeup_valid_q;
   assign wakeup_id     = wakeup_id_q;
   assign overrun_valid = overrun_valid_q;
   assign overrun_id    = overrun_id_q;
   assign overrun_mask  = mask_q;
   assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_edf_release_ctrl.sv
// Testbench for edf_release_ctrl. Reference model tracks, per task, the
// absolute tick number of its next release, plus pending/active sets.
module tb_edf_release_ctrl;
  import edf_pkg::*;

  localparam int N  = MAX_TASKS;
  localparam int IB = MAX_TASK_BITS;
  localparam int TD = TICK_DIV_DEF;
  localparam int VW = 2 * IB + N + 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cfg_valid;
  logic [IB-1:0]     cfg_id;
  logic              cfg_enable;
  logic [TIME_W-1:0] cfg_period;
  logic [TIME_W-1:0] cfg_phase;
  logic              cfg_err;
  logic              completion_valid;
  logic [IB-1:0]     completion_id;
  logic              wakeup_valid;
  logic [IB-1:0]     wakeup_id;
  logic              overrun_valid;
  logic [IB-1:0]     overrun_id;
  logic [N-1:0]      overrun_mask;
  logic              tick;

  edf_release_ctrl #(.TICK_DIV(TD)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_id           (cfg_id),
    .cfg_enable       (cfg_enable),
    .cfg_period       (cfg_period),
    .cfg_phase        (cfg_phase),
    .cfg_err          (cfg_err),
    .completion_valid (completion_valid),
    .completion_id    (completion_id),
    .wakeup_valid     (wakeup_valid),
    .wakeup_id        (wakeup_id),
    .overrun_valid    (overrun_valid),
    .overrun_id       (overrun_id),
    .overrun_mask     (overrun_mask),
    .tick             (tick)
  );

  logic [VW-1:0] obs_vec;
  assign obs_vec = {wakeup_valid, wakeup_id, overrun_valid, overrun_id,
                    overrun_mask, cfg_err, tick};

  int n_tests;
  int n_fail;
  int cyc;

  // ---------------------------------------------------------------- reference model
  bit            m_en   [N];
  int            m_per  [N];
  int            m_next [N];
  bit            m_pend [N];
  bit            m_act  [N];
  bit            m_mask [N];
  int            m_last;
  int            m_presc;
  int            m_ticks;
  logic [VW-1:0] exp_vec;

  // scoreboard: {cycle, id} of expected wakeups
  logic [15:0]   exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_next[i] = 0;
      m_pend[i] = 0; m_act[i] = 0; m_mask[i] = 0;
    end
    m_last = 0; m_presc = 0; m_ticks = 0;
    exp_vec = '0;
  endtask

  // One clock cycle: predict outputs after the edge from current inputs,
  // advance the clock, then return inputs to idle.
  task automatic cycle();
    bit         tick_now, accept, ovr_any, err;
    int         tc, g, ovr_id;
    logic [N-1:0] mask_v;
    tick_now = (m_presc == TD - 1);
    tc       = m_ticks + (tick_now ? 1 : 0);
    accept   = cfg_valid && (!cfg_enable || cfg_period != 0);
    ovr_any  = 0;
    ovr_id   = 0;
    for (int i = 0; i < N; i++) begin
      if (tick_now && m_en[i] && !(accept && int'(cfg_id) == i) && m_next[i] == tc) begin
        m_next[i] += m_per[i];
        if (m_pend[i] || m_act[i]) begin
          m_mask[i] = 1;
          if (!ovr_any) begin ovr_any = 1; ovr_id = i; end
        end
        m_pend[i] = 1;
      end
    end
    if (completion_valid) m_act[completion_id] = 0;
    if (accept) begin
      m_pend[cfg_id] = 0;
      m_act[cfg_id]  = 0;
      if (cfg_enable) begin
        m_en[cfg_id]   = 1;
        m_per[cfg_id]  = int'(cfg_period);
        m_next[cfg_id] = tc + int'(cfg_phase) + 1;
        m_mask[cfg_id] = 0;
      end else begin
        m_en[cfg_id] = 0;
      end
    end
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (g < 0 && m_pend[j]) g = j;
    end
    if (g >= 0) begin
      m_pend[g] = 0;
      m_act[g]  = 1;
      m_last    = g;
    end
    err     = cfg_valid && cfg_enable && cfg_period == 0;
    m_ticks = tc;
    m_presc = tick_now ? 0 : m_presc + 1;
    for (int i = 0; i < N; i++) mask_v[i] = m_mask[i];
    exp_vec = {(g >= 0), (g >= 0) ? IB'(g) : IB'(0), ovr_any, IB'(ovr_id),
               mask_v, err, (m_presc == TD - 1)};
    @(posedge clk);
    #1;
    cyc++;
    cfg_valid        = 1'b0;
    completion_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic do_reset();
    rst = 1'b0;
    cfg_valid = 1'b0;
    completion_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic drive_cfg(input int id, input bit en, input int per, input int ph);
    cfg_valid  = 1'b1;
    cfg_id     = IB'(id);
    cfg_enable = en;
    cfg_period = TIME_W'(per);
    cfg_phase  = TIME_W'(ph);
  endtask

  task automatic drive_completion(input int id);
    completion_valid = 1'b1;
    completion_id    = IB'(id);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0;
    drive_cfg(3, 1, 1, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (obs_vec !== '0) begin
        n_fail++;
        $display("FAIL test_reset held: outputs got %h exp 0", obs_vec);
      end
    end
    cfg_valid = 1'b0;
    model_reset();
    rst = 1'b1;
    cyc = 0;
    repeat (20) begin
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec || wakeup_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL test_reset after: outputs got %h exp %h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_cfg(0, 1, 1, 0);
    while (cyc < 4) cycle();
    n_tests++;
    if (wakeup_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL test_reset_mid beat: wakeup_valid got %b exp 1", wakeup_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (obs_vec !== '0) begin
      n_fail++;
      $display("FAIL test_reset_mid async: outputs got %h exp 0", obs_vec);
    end
  endtask

  task automatic test_single_periodic();
    int n_wake, last_wake, due;
    do_reset();
    n_wake = 0; last_wake = 0; due = -1;
    drive_cfg(2, 1, 20, 0);
    repeat (250) begin
      if (cyc == due) drive_completion(2);
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL test_single_periodic cyc %0d: outputs got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (wakeup_valid === 1'b1) begin
        n_tests++;
        if (wakeup_id !== IB'(2) || cyc != ((n_wake == 0) ? 4 : last_wake + 80)) begin
          n_fail++;
          $display("FAIL test_single_periodic wake: id %0d cyc %0d exp id 2 cyc %0d",
                   wakeup_id, cyc, (n_wake == 0) ? 4 : last_wake + 80);
        end
        last_wake = cyc;
        due = cyc + 10;
        n_wake++;
      end
    end
    n_tests++;
    if (n_wake != 4 || overrun_mask !== '0) begin
      n_fail++;
      $display("FAIL test_single_periodic totals: wakes %0d mask %h exp 4 and 0", n_wake, overrun_mask);
    end
  endtask

  task automatic test_burst();
    logic [15:0] e;
    do_reset();
    exp_q = {};
    exp_q.push_back({12'd4, 4'd1});  exp_q.push_back({12'd5, 4'd3});
    exp_q.push_back({12'd6, 4'd5});  exp_q.push_back({12'd44, 4'd1});
    exp_q.push_back({12'd45, 4'd3}); exp_q.push_back({12'd46, 4'd5});
    for (int c = 0; c < 60; c++) begin
      if (c == 0) drive_cfg(1, 1, 10, 0);
      if (c == 1) drive_cfg(3, 1, 10, 0);
      if (c == 2) drive_cfg(5, 1, 10, 0);
      if (c == 20) drive_completion(1);
      if (c == 21) drive_completion(3);
      if (c == 22) drive_completion(5);
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL test_burst cyc %0d: outputs got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (wakeup_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hffff;
        n_tests++;
        if ({12'(cyc), wakeup_id} !== e) begin
          n_fail++;
          $display("FAIL test_burst order: got cyc %0d id %0d exp cyc %0d id %0d",
                   cyc, wakeup_id, e[15:4], e[3:0]);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL test_burst missing: %0d wakeups not seen exp 0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    drive_cfg(4, 1, 5, 0);
    repeat (30) begin
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL test_overrun cyc %0d: outputs got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (cyc == 24) begin
        n_tests++;
        if (!(wakeup_valid === 1'b1 && wakeup_id === IB'(4) && overrun_valid === 1'b1 &&
              overrun_id === IB'(4) && overrun_mask[4] === 1'b1)) begin
          n_fail++;
          $display("FAIL test_overrun flag: wv %b wid %0d ov %b oid %0d mask %h exp 1 4 1 4 mask[4]=1",
                   wakeup_valid, wakeup_id, overrun_valid, overrun_id, overrun_mask);
        end
      end
    end
    drive_cfg(4, 1, 5, 3);
    cycle();
    n_tests++;
    if (overrun_mask[4] !== 1'b0 || obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL test_overrun recfg: mask %h exp %h", overrun_mask, exp_vec[N+1:2]);
    end
  endtask

  task automatic test_cfg_err_disarm();
    logic [15:0] e;
    do_reset();
    exp_q = {};
    exp_q.push_back({12'd12, 4'd8}); exp_q.push_back({12'd13, 4'd9});
    exp_q.push_back({12'd14, 4'd10});
    for (int c = 0; c < 40; c++) begin
      if (c == 0)  drive_cfg(7, 1, 0, 0);
      if (c == 1)  drive_cfg(8, 1, 100, 2);
      if (c == 2)  drive_cfg(9, 1, 100, 2);
      if (c == 4)  drive_cfg(10, 1, 100, 1);
      if (c == 5)  drive_cfg(11, 1, 100, 1);
      if (c == 12) drive_cfg(11, 0, 0, 0);
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL test_cfg_err_disarm cyc %0d: outputs got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (cyc == 1) begin
        n_tests++;
        if (cfg_err !== 1'b1) begin
          n_fail++;
          $display("FAIL test_cfg_err pulse: cfg_err got %b exp 1", cfg_err);
        end
      end
      if (wakeup_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hffff;
        n_tests++;
        if ({12'(cyc), wakeup_id} !== e) begin
          n_fail++;
          $display("FAIL test_disarm order: got cyc %0d id %0d exp cyc %0d id %0d",
                   cyc, wakeup_id, e[15:4], e[3:0]);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL test_disarm missing: %0d wakeups not seen exp 0", exp_q.size());
    end
  endtask

  task automatic test_completion_collision();
    do_reset();
    drive_cfg(6, 1, 1, 0);
    repeat (14) begin
      if (cyc == 5 || cyc == 7) drive_completion(6);
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL test_collision cyc %0d: outputs got %h exp %h", cyc, obs_vec, exp_vec);
      end
      if (cyc == 8) begin
        n_tests++;
        if (wakeup_valid !== 1'b1 || overrun_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL test_collision clean: wv %b ov %b exp 1 0", wakeup_valid, overrun_valid);
        end
      end
      if (cyc == 12) begin
        n_tests++;
        if (overrun_valid !== 1'b1 || overrun_id !== IB'(6) || overrun_mask[6] !== 1'b1) begin
          n_fail++;
          $display("FAIL test_collision overrun: ov %b id %0d mask %h exp 1 6 mask[6]=1",
                   overrun_valid, overrun_id, overrun_mask);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0)
        drive_cfg($urandom_range(0, N - 1), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
                  $urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) drive_completion($urandom_range(0, N - 1));
      cycle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL test_random cyc %0d: outputs got %h exp %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    cfg_valid = 1'b0; cfg_id = '0; cfg_enable = 1'b0;
    cfg_period = '0; cfg_phase = '0;
    completion_valid = 1'b0; completion_id = '0;
    #2;
    test_reset();
    test_reset_mid();
    test_single_periodic();
    test_burst();
    test_overrun();
    test_cfg_err_disarm();
    test_completion_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
